branch_hazard_ctrl: RTL and testbench

//  Sequences decode-stage branch resolution around branch_unit. Detects RAW hazards on branch/JALR

---
 rtl/branch_hazard_ctrl_if.sv | 39 +++
 rtl/branch_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// Decode-side bundle for branch_hazard_ctrl: ID/EX/MEM hazard inputs in,
// PC/IF-ID/ID-EX control and statistics out.
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             br_enable;
  logic             jalr_enable;
  logic             jal_enable;
  logic             branch_taken;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_memread;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output id_valid, br_enable, jalr_enable, jal_enable, branch_taken,
           id_rs1, id_rs2, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, pc_sel,
           br_count, taken_count
  );

  modport slave (
    input  id_valid, br_enable, jalr_enable, jal_enable, branch_taken,
           id_rs1, id_rs2, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread,
    output pc_write, ifid_write, idex_bubble, ifid_flush, pc_sel,
           br_count, taken_count
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencer: stalls on RAW hazards against branch/JALR
// sources, redirects the PC mux with an IF/ID flush, and counts resolutions.
module branch_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                reset_n,
  branch_hazard_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;
  localparam logic [1:0] SEL_JAL  = 2'b11;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_stall_cnt;
  logic [1:0]       w_stall_cnt_nxt;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [FC_W-1:0]  w_flush_cnt_nxt;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;

  logic       w_chk_rs1;
  logic       w_chk_rs2;
  logic       w_ex_hit;
  logic       w_mem_hit;
  logic       w_need_ld;
  logic       w_need_any;
  logic       w_redirect;
  logic [1:0] w_redir_sel;
  logic       w_resolve;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  // x0 is hardwired zero, so it never forms a dependency
  assign w_chk_rs1 = bus.id_valid & (bus.br_enable | bus.jalr_enable) & (bus.id_rs1 != 5'd0);
  assign w_chk_rs2 = bus.id_valid & bus.br_enable & (bus.id_rs2 != 5'd0);

  assign w_ex_hit  = bus.ex_regwrite &
                     ((w_chk_rs1 & (bus.ex_rd == bus.id_rs1)) |
                      (w_chk_rs2 & (bus.ex_rd == bus.id_rs2)));
  assign w_mem_hit = bus.mem_memread &
                     ((w_chk_rs1 & (bus.mem_rd == bus.id_rs1)) |
                      (w_chk_rs2 & (bus.mem_rd == bus.id_rs2)));

  assign w_need_ld  = w_ex_hit & bus.ex_memread;
  assign w_need_any = w_ex_hit | w_mem_hit;

  always_comb begin
    w_redirect  = 1'b0;
    w_redir_sel = SEL_PC4;
    if (bus.jal_enable) begin
      w_redirect  = 1'b1;
      w_redir_sel = SEL_JAL;
    end else if (bus.jalr_enable) begin
      w_redirect  = 1'b1;
      w_redir_sel = SEL_JALR;
    end else if (bus.br_enable && bus.branch_taken) begin
      w_redirect  = 1'b1;
      w_redir_sel = SEL_BR;
    end
  end

  assign w_resolve = (r_state == RUN) & bus.id_valid & ~w_need_any;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_stall_cnt <= 2'd0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.pc_sel      = SEL_PC4;

    case (r_state)
      RUN: begin
        if (w_need_any) begin
          bus.pc_write    = 1'b0;
          bus.ifid_write  = 1'b0;
          bus.idex_bubble = 1'b1;
          // A load in EX needs one more cycle than a forwardable result
          if (w_need_ld) begin
            w_state_nxt     = STALL;
            w_stall_cnt_nxt = 2'd1;
          end
        end else if (bus.id_valid && w_redirect) begin
          bus.ifid_flush = 1'b1;
          bus.pc_sel     = w_redir_sel;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt     = FLUSH;
            w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      STALL: begin
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_bubble = 1'b1;
        if (r_stall_cnt <= 2'd1) begin
          w_state_nxt     = RUN;
          w_stall_cnt_nxt = 2'd0;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt - 2'd1;
        end
      end
      FLUSH: begin
        bus.ifid_flush = 1'b1;
        if (r_flush_cnt <= FC_W'(1)) begin
          w_state_nxt     = RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_stall_cnt_nxt = 2'd0;
        w_flush_cnt_nxt = '0;
      end
    endcase

    if (!reset_n) begin
      bus.pc_write    = 1'b1;
      bus.ifid_write  = 1'b1;
      bus.idex_bubble = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.pc_sel      = SEL_PC4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else if (w_resolve) begin
      r_br_count    <= sat_inc(r_br_count, bus.br_enable);
      r_taken_count <= sat_inc(r_taken_count, w_redirect);
    end
  end

  assign bus.br_count    = r_br_count;
  assign bus.taken_count = r_taken_count;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Vector-table bench for branch_hazard_ctrl: three instances (default, two-cycle
// flush, 2-bit counters) share one stimulus; expectations go through a scoreboard.
module tb_branch_hazard_ctrl;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_BR   = 4'b1000;
  localparam logic [3:0] OP_BRT  = 4'b1001;
  localparam logic [3:0] OP_JALR = 4'b0100;
  localparam logic [3:0] OP_JAL  = 4'b0010;
  localparam logic [3:0] OP_ALL  = 4'b1111;
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STL   = 4'b0010;
  localparam logic [3:0] C_FL    = 4'b1101;

  typedef struct {
    string      name;
    int         inst;
    logic       rst_n;
    logic       vld;
    logic [3:0] op;
    logic [4:0] rs1, rs2, exrd;
    logic       exrw, exmr;
    logic [4:0] memrd;
    logic       memmr;
    logic [3:0] ctl;
    logic [1:0] sel;
    int         brc, tkc;
  } vec_t;

  logic clk = 1'b0;
  logic r_rst_n = 1'b0;
  logic s_vld = 1'b0;
  logic [3:0] s_op = 4'b0;
  logic [4:0] s_rs1 = 5'd0, s_rs2 = 5'd0, s_exrd = 5'd0, s_memrd = 5'd0;
  logic s_exrw = 1'b0, s_exmr = 1'b0, s_memmr = 1'b0;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl_if #(.CNT_W(16)) bus0 ();
  branch_hazard_ctrl_if #(.CNT_W(16)) bus1 ();
  branch_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus0.id_valid = s_vld;      assign bus1.id_valid = s_vld;      assign bus2.id_valid = s_vld;
  assign bus0.br_enable = s_op[3];   assign bus1.br_enable = s_op[3];   assign bus2.br_enable = s_op[3];
  assign bus0.jalr_enable = s_op[2]; assign bus1.jalr_enable = s_op[2]; assign bus2.jalr_enable = s_op[2];
  assign bus0.jal_enable = s_op[1];  assign bus1.jal_enable = s_op[1];  assign bus2.jal_enable = s_op[1];
  assign bus0.branch_taken = s_op[0]; assign bus1.branch_taken = s_op[0]; assign bus2.branch_taken = s_op[0];
  assign bus0.id_rs1 = s_rs1;        assign bus1.id_rs1 = s_rs1;        assign bus2.id_rs1 = s_rs1;
  assign bus0.id_rs2 = s_rs2;        assign bus1.id_rs2 = s_rs2;        assign bus2.id_rs2 = s_rs2;
  assign bus0.ex_rd = s_exrd;        assign bus1.ex_rd = s_exrd;        assign bus2.ex_rd = s_exrd;
  assign bus0.ex_regwrite = s_exrw;  assign bus1.ex_regwrite = s_exrw;  assign bus2.ex_regwrite = s_exrw;
  assign bus0.ex_memread = s_exmr;   assign bus1.ex_memread = s_exmr;   assign bus2.ex_memread = s_exmr;
  assign bus0.mem_rd = s_memrd;      assign bus1.mem_rd = s_memrd;      assign bus2.mem_rd = s_memrd;
  assign bus0.mem_memread = s_memmr; assign bus1.mem_memread = s_memmr; assign bus2.mem_memread = s_memmr;

  branch_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut    (.clk(clk), .reset_n(r_rst_n), .bus(bus0));
  branch_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut_f2 (.clk(clk), .reset_n(r_rst_n), .bus(bus1));
  branch_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2))  u_dut_c2 (.clk(clk), .reset_n(r_rst_n), .bus(bus2));

  function automatic void add(string nm, int inst, logic rst_n, logic vld, logic [3:0] op,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] exrd,
                              logic exrw, logic exmr, logic [4:0] memrd, logic memmr,
                              logic [3:0] ctl, logic [1:0] sel, int brc, int tkc);
    vec_t v;
    v.name = nm; v.inst = inst; v.rst_n = rst_n; v.vld = vld; v.op = op;
    v.rs1 = rs1; v.rs2 = rs2; v.exrd = exrd; v.exrw = exrw; v.exmr = exmr;
    v.memrd = memrd; v.memmr = memmr; v.ctl = ctl; v.sel = sel; v.brc = brc; v.tkc = tkc;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
  endtask

  always @(negedge clk) begin
    vec_t e;
    logic [3:0] actl;
    logic [1:0] asel;
    logic [31:0] abr, atk;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        1: begin
          actl = {bus1.pc_write, bus1.ifid_write, bus1.idex_bubble, bus1.ifid_flush};
          asel = bus1.pc_sel; abr = 32'(bus1.br_count); atk = 32'(bus1.taken_count);
        end
        2: begin
          actl = {bus2.pc_write, bus2.ifid_write, bus2.idex_bubble, bus2.ifid_flush};
          asel = bus2.pc_sel; abr = 32'(bus2.br_count); atk = 32'(bus2.taken_count);
        end
        default: begin
          actl = {bus0.pc_write, bus0.ifid_write, bus0.idex_bubble, bus0.ifid_flush};
          asel = bus0.pc_sel; abr = 32'(bus0.br_count); atk = 32'(bus0.taken_count);
        end
      endcase
      chk(e.name, "ctl{pcw,ifidw,bub,flush}", 32'(actl), 32'(e.ctl));
      chk(e.name, "pc_sel", 32'(asel), 32'(e.sel));
      if (e.brc >= 0) chk(e.name, "br_count", abr, 32'(e.brc));
      if (e.tkc >= 0) chk(e.name, "taken_count", atk, 32'(e.tkc));
    end
  end

  initial begin
    // name, inst, rst_n, vld, op, rs1, rs2, exrd, exrw, exmr, memrd, memmr, ctl, sel, brc, tkc
    add("rst_hold",   0, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 0, 0);
    add("idle",       0, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 0, 0);
    add("beq_ld_s1",  0, 1, 1, OP_BR,   5, 0, 5, 1, 1, 0, 0, C_STL, 2'b00, 0, 0);
    add("beq_ld_s2",  0, 1, 1, OP_BR,   5, 0, 0, 0, 0, 5, 1, C_STL, 2'b00, 0, 0);
    add("beq_taken",  0, 1, 1, OP_BRT,  5, 0, 0, 0, 0, 0, 0, C_FL,  2'b01, 0, 0);
    add("after_beq",  0, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 1, 1);
    add("bne_alu_s",  0, 1, 1, OP_BR,   1, 7, 7, 1, 0, 0, 0, C_STL, 2'b00, 1, 1);
    add("bne_nt",     0, 1, 1, OP_BR,   1, 7, 0, 0, 0, 7, 0, C_RUN, 2'b00, 1, 1);
    add("after_bne",  0, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2, 1);
    add("jalr_mem_s", 0, 1, 1, OP_JALR, 9, 0, 0, 0, 0, 9, 1, C_STL, 2'b00, 2, 1);
    add("jalr_go",    0, 1, 1, OP_JALR, 9, 0, 0, 0, 0, 9, 0, C_FL,  2'b10, 2, 1);
    add("jal_noStl",  0, 1, 1, OP_JAL,  5, 0, 5, 1, 1, 0, 0, C_FL,  2'b11, 2, 2);
    add("jalr_x0",    0, 1, 1, OP_JALR, 0, 0, 0, 1, 1, 0, 0, C_FL,  2'b10, 2, 3);
    add("prio_jal",   0, 1, 1, OP_ALL,  3, 4, 0, 0, 0, 0, 0, C_FL,  2'b11, 2, 4);
    add("invalid_id", 0, 1, 0, OP_BRT,  0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 3, 5);
    add("jalr_rs2ig", 0, 1, 1, OP_JALR, 1, 6, 6, 1, 1, 0, 0, C_FL,  2'b10, 3, 5);
    add("stall_ent",  0, 1, 1, OP_BR,   5, 0, 5, 1, 1, 0, 0, C_STL, 2'b00, 3, 6);
    add("rst_midstl", 0, 0, 1, OP_BR,   5, 0, 5, 1, 1, 0, 0, C_RUN, 2'b00, 3, 6);
    add("rst_2nd",    0, 0, 1, OP_BR,   5, 0, 5, 1, 1, 0, 0, C_RUN, 2'b00, 0, 0);
    add("post_rst",   0, 1, 1, OP_BRT,  5, 0, 0, 0, 0, 0, 0, C_FL,  2'b01, 0, 0);
    add("post_rst2",  0, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 1, 1);
    add("f2_rst_a",   1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, -1, -1);
    add("f2_rst_b",   1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 0, 0);
    add("f2_taken",   1, 1, 1, OP_BRT,  1, 0, 0, 0, 0, 0, 0, C_FL,  2'b01, 0, 0);
    add("f2_flush2",  1, 1, 1, OP_BRT,  2, 0, 2, 1, 1, 0, 0, C_FL,  2'b00, 1, 1);
    add("f2_after",   1, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 1, 1);
    add("c2_rst_a",   2, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, -1, -1);
    add("c2_rst_b",   2, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 0, 0);
    for (int k = 0; k < 5; k++)
      add($sformatf("c2_tk%0d", k), 2, 1, 1, OP_BRT, 0, 0, 0, 0, 0, 0, 0, C_FL, 2'b01,
          (k > 3) ? 3 : k, (k > 3) ? 3 : k);
    add("c2_sat",     2, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 3, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      r_rst_n = tbl[i].rst_n; s_vld = tbl[i].vld; s_op = tbl[i].op;
      s_rs1 = tbl[i].rs1; s_rs2 = tbl[i].rs2; s_exrd = tbl[i].exrd;
      s_exrw = tbl[i].exrw; s_exmr = tbl[i].exmr; s_memrd = tbl[i].memrd; s_memmr = tbl[i].memmr;
      sb.push_back(tbl[i]);
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    chk("scoreboard", "pending", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
